// File: rtl/time_keeper.sv
//------------------------------------------------------------------------------
// Module   : time_keeper
// Purpose  : Time-of-day (hh:mm:ss), date (month/day) and alarm (hh:mm)
//            keeper driven by the mode generator's mode1/mode2/increase.
//            Time advances once per CLK_PER_SEC cycles, fields are bumped one
//            step per increase pulse, and alarm_ring is raised for RING_SECS
//            seconds when the running time hits an armed alarm.
// Ports    : clk        - system clock, rising edge
//            reset_n    - asynchronous active-low reset
//            mode1      - major mode (TIME=0, DATE=1, TIMER=2, ALARM=3)
//            mode2      - minor mode (G=0, HOUR/MON=1, MIN/DAY=2, SEC=3)
//            increase   - one-cycle adjust pulse
//            hour/min/sec, month/day, alarm_hour/alarm_min - current values
//            alarm_ring - alarm active level
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module time_keeper #(
  parameter int CLK_PER_SEC = 100,
  parameter int RING_SECS   = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] mode1,
  input  logic [1:0] mode2,
  input  logic       increase,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       alarm_ring
);

  localparam logic [1:0] M1_TIME  = 2'd0;
  localparam logic [1:0] M1_DATE  = 2'd1;
  localparam logic [1:0] M1_ALARM = 2'd3;

  localparam logic [1:0] M2_G    = 2'd0;
  localparam logic [1:0] M2_HOUR = 2'd1;
  localparam logic [1:0] M2_MIN  = 2'd2;
  localparam logic [1:0] M2_SEC  = 2'd3;
  localparam logic [1:0] M2_MON  = 2'd1;
  localparam logic [1:0] M2_DAY  = 2'd2;

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_SEC - 1);
  localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RINGING = 1'b1
  } ring_state_t;

  function automatic logic [4:0] days_in_month(input logic [3:0] m);
    logic [4:0] d;
    case (m)
      4'd2:                     d = 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  d = 5'd30;
      default:                  d = 5'd31;
    endcase
    return d;
  endfunction

  logic [PW-1:0] prescaler;
  logic          armed;
  logic [1:0]    prev_mode1;
  ring_state_t   state;
  logic [RW-1:0] ring_cnt;

  logic          freeze;
  logic          tick;
  logic          date_inc;
  logic          midnight;
  logic          ring_match;
  logic [4:0]    n_hour;
  logic [5:0]    n_min;
  logic [5:0]    n_sec;
  logic [3:0]    n_month;
  logic [4:0]    n_day;
  logic [4:0]    n_alarm_hour;
  logic [5:0]    n_alarm_min;
  logic          n_armed;

  always_comb begin
    freeze   = (mode1 == M1_TIME) && (mode2 != M2_G);
    tick     = !freeze && (prescaler == PRE_MAX);
    date_inc = increase && (mode1 == M1_DATE) &&
               ((mode2 == M2_MON) || (mode2 == M2_DAY));
    midnight     = 1'b0;
    n_hour       = hour;
    n_min        = min;
    n_sec        = sec;
    n_month      = month;
    n_day        = day;
    n_alarm_hour = alarm_hour;
    n_alarm_min  = alarm_min;
    n_armed      = armed;

    // Seconds carry chain
    if (tick) begin
      if (sec == 6'd59) begin
        n_sec = 6'd0;
        if (min == 6'd59) begin
          n_min = 6'd0;
          if (hour == 5'd23) begin
            n_hour   = 5'd0;
            midnight = 1'b1;
          end else begin
            n_hour = hour + 5'd1;
          end
        end else begin
          n_min = min + 6'd1;
        end
      end else begin
        n_sec = sec + 6'd1;
      end
    end

    // A date adjustment in the same cycle overrides the midnight date carry
    if (midnight && !date_inc) begin
      if (day == days_in_month(month)) begin
        n_day   = 5'd1;
        n_month = (month == 4'd12) ? 4'd1 : month + 4'd1;
      end else begin
        n_day = day + 5'd1;
      end
    end

    // Single-field adjust, wrapping within the field, never carrying.
    // Time fields cannot collide with a tick: adjusting them freezes time.
    if (increase) begin
      case (mode1)
        M1_TIME: begin
          case (mode2)
            M2_HOUR: n_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            M2_MIN:  n_min  = (min == 6'd59) ? 6'd0 : min + 6'd1;
            M2_SEC:  n_sec  = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
            default: ;
          endcase
        end
        M1_DATE: begin
          case (mode2)
            M2_MON: begin
              n_month = (month == 4'd12) ? 4'd1 : month + 4'd1;
              if (day > days_in_month(n_month)) begin
                n_day = days_in_month(n_month);
              end
            end
            M2_DAY:  n_day = (day == days_in_month(month)) ? 5'd1 : day + 5'd1;
            default: ;
          endcase
        end
        M1_ALARM: begin
          case (mode2)
            M2_HOUR: begin
              n_alarm_hour = (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
              n_armed      = 1'b1;
            end
            M2_MIN: begin
              n_alarm_min = (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
              n_armed     = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    // Match is judged against the values that will be visible after this edge
    ring_match = tick && n_armed && (n_hour == n_alarm_hour) &&
                 (n_min == n_alarm_min) && (n_sec == 6'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler  <= '0;
      hour       <= 5'd0;
      min        <= 6'd0;
      sec        <= 6'd0;
      month      <= 4'd1;
      day        <= 5'd1;
      alarm_hour <= 5'd0;
      alarm_min  <= 6'd0;
      armed      <= 1'b0;
      prev_mode1 <= M1_TIME;
      state      <= ST_IDLE;
      ring_cnt   <= '0;
      alarm_ring <= 1'b0;
    end else begin
      if (freeze || tick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      hour       <= n_hour;
      min        <= n_min;
      sec        <= n_sec;
      month      <= n_month;
      day        <= n_day;
      alarm_hour <= n_alarm_hour;
      alarm_min  <= n_alarm_min;
      armed      <= n_armed;
      prev_mode1 <= mode1;

      case (state)
        ST_IDLE: begin
          if (ring_match) begin
            state      <= ST_RINGING;
            alarm_ring <= 1'b1;
            ring_cnt   <= '0;
          end
        end
        ST_RINGING: begin
          if (mode1 != prev_mode1) begin
            state      <= ST_IDLE;
            alarm_ring <= 1'b0;
          end else if (tick) begin
            if (ring_cnt == RING_LAST) begin
              state      <= ST_IDLE;
              alarm_ring <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 1'b1;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          alarm_ring <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_time_keeper.sv
//------------------------------------------------------------------------------
// Module   : tb_time_keeper
// Purpose  : Self-checking bench for time_keeper. A seconds-of-day / date /
//            alarm-minutes model is compared with the DUT on every cycle;
//            directed scenarios add literal expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_time_keeper;

  localparam int CPS = 5;
  localparam int RS  = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mode1 = 2'd0;
  logic [1:0] mode2 = 2'd0;
  logic       increase = 1'b0;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [3:0] month;
  logic [4:0] day;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_ring;

  time_keeper #(.CLK_PER_SEC(CPS), .RING_SECS(RS)) dut (
    .clk(clk), .reset_n(reset_n), .mode1(mode1), .mode2(mode2),
    .increase(increase), .hour(hour), .min(min), .sec(sec),
    .month(month), .day(day), .alarm_hour(alarm_hour),
    .alarm_min(alarm_min), .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_tsec = 0;      // seconds since midnight
  int m_mon  = 1;
  int m_day  = 1;
  int m_amin = 0;      // alarm as minutes since midnight
  int m_pre  = 0;
  bit m_armed = 0;
  bit m_ring  = 0;
  int m_rcnt  = 0;
  int m_prev_m1 = 0;
  bit m_tick, m_dinc, m_cancel;

  function automatic int dim(input int m);
    case (m)
      2:           return 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_tsec = 0; m_mon = 1; m_day = 1; m_amin = 0; m_pre = 0;
      m_armed = 0; m_ring = 0; m_rcnt = 0; m_prev_m1 = 0;
    end else begin
      m_tick = 0;
      if (mode1 == 0 && mode2 != 0) m_pre = 0;
      else if (m_pre == CPS - 1) begin m_pre = 0; m_tick = 1; end
      else m_pre++;
      m_dinc = increase && mode1 == 1 && (mode2 == 1 || mode2 == 2);
      if (m_tick) begin
        m_tsec = (m_tsec + 1) % 86400;
        if (m_tsec == 0 && !m_dinc) begin
          if (m_day == dim(m_mon)) begin m_day = 1; m_mon = m_mon % 12 + 1; end
          else m_day++;
        end
      end
      if (increase) begin
        if (mode1 == 0 && mode2 == 1)
          m_tsec = ((m_tsec / 3600 + 1) % 24) * 3600 + m_tsec % 3600;
        else if (mode1 == 0 && mode2 == 2)
          m_tsec = (m_tsec / 3600) * 3600 + (((m_tsec / 60) % 60 + 1) % 60) * 60 + m_tsec % 60;
        else if (mode1 == 0 && mode2 == 3)
          m_tsec = m_tsec - m_tsec % 60 + (m_tsec % 60 + 1) % 60;
        else if (mode1 == 1 && mode2 == 1) begin
          m_mon = m_mon % 12 + 1;
          if (m_day > dim(m_mon)) m_day = dim(m_mon);
        end else if (mode1 == 1 && mode2 == 2)
          m_day = m_day % dim(m_mon) + 1;
        else if (mode1 == 3 && mode2 == 1) begin
          m_amin = ((m_amin / 60 + 1) % 24) * 60 + m_amin % 60; m_armed = 1;
        end else if (mode1 == 3 && mode2 == 2) begin
          m_amin = (m_amin / 60) * 60 + (m_amin % 60 + 1) % 60; m_armed = 1;
        end
      end
      m_cancel = (int'(mode1) != m_prev_m1);
      m_prev_m1 = int'(mode1);
      if (m_ring) begin
        if (m_cancel) m_ring = 0;
        else if (m_tick) begin
          m_rcnt++;
          if (m_rcnt == RS) m_ring = 0;
        end
      end else if (m_tick && m_armed && m_tsec == m_amin * 60) begin
        m_ring = 1; m_rcnt = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hour", hour, m_tsec / 3600);
      chk("min", min, (m_tsec / 60) % 60);
      chk("sec", sec, m_tsec % 60);
      chk("month", month, m_mon);
      chk("day", day, m_day);
      chk("alarm_hour", alarm_hour, m_amin / 60);
      chk("alarm_min", alarm_min, m_amin % 60);
      chk("alarm_ring", alarm_ring, m_ring);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  function automatic int field(input int m1, input int m2);
    if (m1 == 0 && m2 == 1) return m_tsec / 3600;
    if (m1 == 0 && m2 == 2) return (m_tsec / 60) % 60;
    if (m1 == 0 && m2 == 3) return m_tsec % 60;
    if (m1 == 1 && m2 == 1) return m_mon;
    if (m1 == 1 && m2 == 2) return m_day;
    if (m1 == 3 && m2 == 1) return m_amin / 60;
    return m_amin % 60;
  endfunction

  task automatic pulse();
    increase = 1'b1; cyc();
    increase = 1'b0; cyc();
  endtask

  task automatic set_to(input int m1, input int m2, input int target);
    mode1 = 2'(m1); mode2 = 2'(m2); increase = 1'b0;
    cyc();
    for (int k = 0; k < 64 && field(m1, m2) != target; k++) pulse();
  endtask

  task automatic go_time_g();
    mode1 = 2'd0; mode2 = 2'd0; increase = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mode1 = 2'd0; mode2 = 2'd0; increase = 1'b0;
    cycn(2);
    reset_n = 1'b1;
  endtask

  task automatic lit_time(input string nm, input int h, input int mi, input int s,
                          input int mo, input int d);
    chk({nm, "_hour"}, hour, h);
    chk({nm, "_min"}, min, mi);
    chk({nm, "_sec"}, sec, s);
    chk({nm, "_month"}, month, mo);
    chk({nm, "_day"}, day, d);
  endtask

  int s0;

  initial begin
    do_reset();
    chk_en = 1'b1;
    lit_time("reset", 0, 0, 0, 1, 1);
    chk("reset_alarm_hour", alarm_hour, 0);
    chk("reset_alarm_min", alarm_min, 0);
    chk("reset_ring", alarm_ring, 0);

    // 23:59:59 on 02/28 -> 00:00:00 on 03/01
    set_to(1, 1, 2); set_to(1, 2, 28);
    set_to(0, 1, 23); set_to(0, 2, 59); set_to(0, 3, 59);
    go_time_g();
    cycn(CPS - 1);
    chk("feb_pre_tick_sec", sec, 59);
    cyc();
    lit_time("feb_rollover", 0, 0, 0, 3, 1);

    // 23:59:59 on 12/31 -> 00:00:00 on 01/01
    set_to(1, 1, 12); set_to(1, 2, 31);
    set_to(0, 1, 23); set_to(0, 2, 59); set_to(0, 3, 59);
    go_time_g();
    cycn(CPS);
    lit_time("year_rollover", 0, 0, 0, 1, 1);

    // Month adjust clamps the day
    set_to(1, 2, 31);
    mode1 = 2'd1; mode2 = 2'd1; pulse();
    chk("clamp_month", month, 2);
    chk("clamp_day", day, 28);

    // Minute adjust wraps without carry
    set_to(0, 2, 59);
    pulse();
    chk("min_wrap_min", min, 0);
    chk("min_wrap_hour", hour, 0);

    // Freeze while adjusting, then a full second after returning to G
    mode1 = 2'd0; mode2 = 2'd3; cyc();
    s0 = m_tsec % 60;
    cycn(5 * CPS);
    chk("freeze_sec", sec, s0);
    go_time_g();
    cycn(CPS - 1);
    chk("resume_pre_sec", sec, s0);
    cyc();
    chk("resume_sec", sec, (s0 + 1) % 60);

    // Armed alarm at 00:01, expires after RS ticks
    set_to(3, 2, 1);
    set_to(0, 1, 0); set_to(0, 2, 0); set_to(0, 3, 59);
    go_time_g();
    cycn(CPS - 1);
    chk("ring_pre", alarm_ring, 0);
    cyc();
    chk("ring_rise", alarm_ring, 1);
    cycn((RS - 1) * CPS);
    chk("ring_hold", alarm_ring, 1);
    cycn(CPS);
    chk("ring_expire", alarm_ring, 0);

    // Second run, cancelled by a mode1 change
    set_to(0, 2, 0); set_to(0, 3, 59);
    go_time_g();
    cycn(CPS);
    chk("ring_rise2", alarm_ring, 1);
    cycn(2 * CPS);
    mode1 = 2'd1;
    cyc();
    chk("ring_cancel", alarm_ring, 0);

    // Unarmed alarm at 00:00 through midnight
    do_reset();
    set_to(0, 1, 23); set_to(0, 2, 59); set_to(0, 3, 59);
    go_time_g();
    cycn(3 * CPS);
    chk("unarmed_ring", alarm_ring, 0);
    lit_time("day_carry", 0, 0, 2, 1, 2);

    // Arm 00:00 (24 hour bumps), ring at midnight, then async reset
    mode1 = 2'd3; mode2 = 2'd1;
    for (int i = 0; i < 24; i++) pulse();
    set_to(0, 1, 23); set_to(0, 2, 59); set_to(0, 3, 59);
    go_time_g();
    cycn(CPS);
    chk("ring_midnight", alarm_ring, 1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk("ring_async_reset", alarm_ring, 0);
    cyc();
    reset_n = 1'b1;

    // Random mode / adjust traffic
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(7) == 0) begin
        mode1 = 2'($urandom_range(3));
        mode2 = 2'($urandom_range(3));
      end
      increase = ($urandom_range(3) == 0);
      cyc();
    end
    increase = 1'b0;
    cycn(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
